room_temp_model: RTL and testbench
==================================

Name: room_temp_model

Overview:
- Synthesisable thermal-plant model: the other end of the air-conditioner control interface.
- Consumes heating/cooling commands and produces the 5-bit room temperature the controller reads.
- Closes the loop for the AC controller in closed-loop benches and FPGA demos: temperature rises under heating, falls under cooling, and drifts toward ambient when idle.

Parameters:
- INIT_TEMP, 20, temperature loaded on reset (0..31)
- AMBIENT, 16, idle drift target (0..31)
- HEAT_DIV, 4, cycles per +1 step while heating (>=1)
- COOL_DIV, 4, cycles per -1 step while cooling (>=1)
- DRIFT_DIV, 16, cycles per 1-degree drift step while idle (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- enable  in  1  1 = model runs; 0 = freeze temperature, counters and state
- heating  in  1  heat command from controller
- cooling  in  1  cool command from controller
- load  in  1  force temperature to load_value
- load_value  in  5  value written when load=1
- temperature  out  5  registered room temperature, unsigned degrees
- at_min  out  1  temperature == 0
- at_max  out  1  temperature == 31
- fault  out  1  registered; heating and cooling both high last cycle

Behaviour:
- Reset (rst=1 at edge):
  - temperature=INIT_TEMP; state=IDLE; prescaler=0; fault=0.
  - at_min and at_max are combinational from temperature.
  - rst overrides load and enable.
- Priority at each edge: rst > load > !enable > normal operation.
- Load:
  - temperature=load_value; prescaler=0; state unchanged.
  - Applies even when enable=0.
- State register (IDLE, HEAT, COOL, FAULT), updated each enabled edge from the sampled inputs:
  - heating&!cooling -> HEAT
  - cooling&!heating -> COOL
  - both high -> FAULT
  - neither -> IDLE
- fault=1 exactly while state==FAULT.
- Prescaler:
  - One shared counter, width $clog2 of the largest DIV (minimum 1 bit).
  - Cleared to 0 on any state change.
  - Otherwise increments each enabled cycle.
  - On reaching DIV-1 for the current state it wraps to 0 and issues a step.
- Steps:
  - HEAT: temperature+1, saturating at 31.
  - COOL: temperature-1, saturating at 0.
  - IDLE: move 1 toward AMBIENT; hold if equal.
  - FAULT: no step; temperature held, prescaler held at 0.
- Latency:
  - Input sampled at edge N sets state at N.
  - First step lands at edge N+DIV (prescaler counts 0..DIV-1 from N+1).
  - Subsequent steps every DIV edges.
- Saturation: at the limit, steps are absorbed. The prescaler keeps cycling; no wrap-around ever.
- DIV=1: one step per enabled cycle after state entry.
- enable=0: nothing changes except via rst or load. On re-enable, counting resumes from the held prescaler value.
- Mid-ramp reset: returns to INIT_TEMP next edge; any partial prescaler count is lost.

Optional Feature:
- Macro: ROOM_TEMP_NOISE_EN.
- Defined:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, seeded 8'hA5 on rst.
  - Advances every enabled cycle.
  - On an IDLE drift step with lfsr[1:0]==2'b00, temperature moves 1 away from AMBIENT instead (saturating).
  - When temperature==AMBIENT, the step goes up.
- Undefined: no LFSR logic; IDLE drift is deterministic as above.

Test Plan:
- Reset: rst=1 then 0, heating=cooling=0, defaults -> temperature=20 immediately after reset; idle drift reaches 19 at the 16th enabled edge, reaches 16 after 64 cycles, then holds at 16.
- Heating ramp: load 20, hold heating=1 -> temperature 21 at edge N+4, 22 at N+8; then load 30, heat 20 cycles -> reaches 31, holds 31, at_max=1, never wraps to 0.
- Cooling ramp: load 2, cooling=1 -> 1 at N+4, 0 at N+8, holds 0 with at_min=1 thereafter.
- Fault: heating=cooling=1 for 10 cycles from temperature 20 -> fault=1 from first edge, temperature stays 20; drop cooling -> fault=0 next edge, 21 appears 4 edges later.
- Freeze and load: mid-heat set enable=0 for 7 cycles -> temperature and prescaler frozen; load=1 load_value=5 while frozen -> temperature=5 next edge; re-enable -> ramp resumes from 5.
- Closed loop: connect to the AC controller, start at 16 -> temperature rises under heating, the controller switches modes, and the heating&cooling fault never asserts over 1000 cycles.

Source files
------------

// File: rtl/room_temp_model.sv
// Thermal plant model for the AC controller: heats, cools, or drifts toward ambient.
// Optional macro ROOM_TEMP_NOISE_EN adds LFSR-driven perturbation of idle drift.
module room_temp_model #(
   parameter int INIT_TEMP = 20,
   parameter int AMBIENT   = 16,
   parameter int HEAT_DIV  = 4,
   parameter int COOL_DIV  = 4,
   parameter int DRIFT_DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       heating,
   input  logic       cooling,
   input  logic       load,
   input  logic [4:0] load_value,
   output logic [4:0] temperature,
   output logic       at_min,
   output logic       at_max,
   output logic       fault
);

   localparam int MAXDIV = (HEAT_DIV > COOL_DIV) ?
                           ((HEAT_DIV > DRIFT_DIV) ? HEAT_DIV : DRIFT_DIV) :
                           ((COOL_DIV > DRIFT_DIV) ? COOL_DIV : DRIFT_DIV);
   localparam int PW = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;

   localparam logic [PW-1:0] HEAT_M1  = PW'(HEAT_DIV - 1);
   localparam logic [PW-1:0] COOL_M1  = PW'(COOL_DIV - 1);
   localparam logic [PW-1:0] DRIFT_M1 = PW'(DRIFT_DIV - 1);
   localparam logic [4:0]    INIT_T   = 5'(INIT_TEMP);
   localparam logic [4:0]    AMB      = 5'(AMBIENT);

   typedef enum logic [1:0] {S_IDLE, S_HEAT, S_COOL, S_FAULT} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] psc, psc_nxt, div_m1;
   logic          step;
   logic [4:0]    temp_nxt;
   logic          noise_away;

`ifdef ROOM_TEMP_NOISE_EN
   logic [7:0] lfsr;
   logic       lfsr_fb;

   assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign noise_away = (lfsr[1:0] == 2'b00);

   always_ff @(posedge clk) begin
      if (rst)
         lfsr <= 8'hA5;
      else if (enable)
         lfsr <= {lfsr[6:0], lfsr_fb};
   end
`else
   assign noise_away = 1'b0;
`endif

   always_comb begin
      state_nxt = S_IDLE;
      unique case ({heating, cooling})
         2'b10:   state_nxt = S_HEAT;
         2'b01:   state_nxt = S_COOL;
         2'b11:   state_nxt = S_FAULT;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      div_m1 = '0;
      unique case (state)
         S_HEAT:  div_m1 = HEAT_M1;
         S_COOL:  div_m1 = COOL_M1;
         S_IDLE:  div_m1 = DRIFT_M1;
         default: div_m1 = '0;
      endcase
   end

   // A state change restarts the count; FAULT parks the prescaler at zero.
   always_comb begin
      psc_nxt = '0;
      step    = 1'b0;
      if (state_nxt == state && state != S_FAULT) begin
         if (psc == div_m1)
            step = 1'b1;
         else
            psc_nxt = psc + 1'b1;
      end
   end

   always_comb begin
      temp_nxt = temperature;
      if (step) begin
         unique case (state)
            S_HEAT: if (temperature != 5'd31) temp_nxt = temperature + 5'd1;
            S_COOL: if (temperature != 5'd0)  temp_nxt = temperature - 5'd1;
            S_IDLE: begin
               if (noise_away) begin
                  // At ambient, "away" resolves upward.
                  if (temperature >= AMB) begin
                     if (temperature != 5'd31) temp_nxt = temperature + 5'd1;
                  end else if (temperature != 5'd0) begin
                     temp_nxt = temperature - 5'd1;
                  end
               end else if (temperature > AMB) begin
                  temp_nxt = temperature - 5'd1;
               end else if (temperature < AMB) begin
                  temp_nxt = temperature + 5'd1;
               end
            end
            default: temp_nxt = temperature;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         psc         <= '0;
         temperature <= INIT_T;
         fault       <= 1'b0;
      end else if (load) begin
         psc         <= '0;
         temperature <= load_value;
      end else if (enable) begin
         state       <= state_nxt;
         psc         <= psc_nxt;
         temperature <= temp_nxt;
         fault       <= (state_nxt == S_FAULT);
      end
   end

   assign at_min = (temperature == 5'd0);
   assign at_max = (temperature == 5'd31);

endmodule

// File: tb/tb_room_temp_model.sv
// Self-checking bench for room_temp_model: directed plan scenarios, random traffic,
// and a bang-bang closed loop, all checked against a mode/age behavioural model.
module tb_room_temp_model;

   logic       clk = 1'b0;
   logic       rst, enable, heating, cooling, load;
   logic [4:0] load_value;
   logic [4:0] temperature;
   logic       at_min, at_max, fault;

   room_temp_model dut (
      .clk(clk), .rst(rst), .enable(enable), .heating(heating), .cooling(cooling),
      .load(load), .load_value(load_value), .temperature(temperature),
      .at_min(at_min), .at_max(at_max), .fault(fault)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: mode 0 idle, 1 heat, 2 cool, 3 fault; age counts edges spent in mode
   int m_temp = 20;
   int m_mode = 0;
   int m_age  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int div_of(input int mode);
      case (mode)
         1:       return 4;
         2:       return 4;
         default: return 16;
      endcase
   endfunction

   // Advance one clock, update the model from the inputs held across the edge, check.
   task automatic tick();
      int nm;
      @(posedge clk);
      #1;
      if (rst) begin
         m_temp = 20; m_mode = 0; m_age = 0;
      end else if (load) begin
         m_temp = int'(load_value); m_age = 0;
      end else if (enable) begin
         nm = (heating && !cooling) ? 1 : (cooling && !heating) ? 2 :
              (heating && cooling) ? 3 : 0;
         if (nm != m_mode) begin
            m_mode = nm; m_age = 0;
         end else if (m_mode != 3) begin
            m_age++;
            if (m_age % div_of(m_mode) == 0) begin
               if (m_mode == 1)      m_temp = (m_temp < 31) ? m_temp + 1 : 31;
               else if (m_mode == 2) m_temp = (m_temp > 0) ? m_temp - 1 : 0;
               else if (m_temp > 16) m_temp = m_temp - 1;
               else if (m_temp < 16) m_temp = m_temp + 1;
            end
         end
      end
      chk("temp",   32'(temperature), 32'(m_temp));
      chk("fault",  32'(fault),       32'(m_mode == 3));
      chk("at_min", 32'(at_min),      32'(m_temp == 0));
      chk("at_max", 32'(at_max),      32'(m_temp == 31));
   endtask

   task automatic do_load(input int v);
      load = 1'b1; load_value = 5'(v);
      tick();
      load = 1'b0;
   endtask

   initial begin
      int switched;
      rst = 1'b1; enable = 1'b1; heating = 1'b0; cooling = 1'b0;
      load = 1'b0; load_value = '0;

      // Reset and idle drift toward ambient
      tick(); tick();
      rst = 1'b0;
      chk("rst_temp", 32'(temperature), 32'd20);
      for (int i = 1; i <= 80; i++) begin
         tick();
         if (i == 15) chk("drift_pre19", 32'(temperature), 32'd20);
         if (i == 16) chk("drift_19",    32'(temperature), 32'd19);
         if (i == 64) chk("drift_16",    32'(temperature), 32'd16);
      end
      chk("drift_hold", 32'(temperature), 32'd16);

      // Heating ramp and saturation at 31
      do_load(20);
      heating = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         tick();
         if (i == 3) chk("heat_n3", 32'(temperature), 32'd20);
         if (i == 4) chk("heat_21", 32'(temperature), 32'd21);
         if (i == 8) chk("heat_22", 32'(temperature), 32'd22);
      end
      do_load(30);
      for (int i = 0; i < 20; i++) tick();
      chk("heat_sat",   32'(temperature), 32'd31);
      chk("heat_atmax", 32'(at_max),      32'd1);

      // Cooling ramp and saturation at 0
      do_load(2);
      heating = 1'b0; cooling = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         tick();
         if (i == 4) chk("cool_1", 32'(temperature), 32'd1);
         if (i == 8) chk("cool_0", 32'(temperature), 32'd0);
      end
      chk("cool_atmin", 32'(at_min), 32'd1);

      // Fault: both commands high
      do_load(20);
      heating = 1'b1; cooling = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) chk("fault_first", 32'(fault), 32'd1);
      end
      chk("fault_hold", 32'(temperature), 32'd20);
      cooling = 1'b0;
      tick();
      chk("fault_clr", 32'(fault), 32'd0);
      for (int i = 1; i <= 4; i++) tick();
      chk("fault_21", 32'(temperature), 32'd21);

      // Freeze mid-heat, load while frozen, resume
      tick(); tick();
      enable = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("freeze", 32'(temperature), 32'(m_temp));
      do_load(5);
      chk("frozen_load", 32'(temperature), 32'd5);
      enable = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("resume", 32'(temperature), 32'd7);

      // Randomized traffic
      for (int i = 0; i < 2500; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         load       = ($urandom_range(0, 29) == 0);
         load_value = 5'($urandom);
         enable     = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 9) == 0) begin
            heating = 1'($urandom);
            cooling = 1'($urandom);
         end
         tick();
      end
      rst = 1'b0; load = 1'b0; enable = 1'b1;

      // Closed loop with a hysteretic controller that never commands both
      heating = 1'b0; cooling = 1'b0;
      do_load(16);
      switched = 0;
      for (int i = 0; i < 1000; i++) begin
         if (!heating && !cooling && temperature <= 5'd17) begin
            heating = 1'b1; switched++;
         end else if (heating && temperature >= 5'd24) begin
            heating = 1'b0; cooling = 1'b1; switched++;
         end else if (cooling && temperature <= 5'd14) begin
            cooling = 1'b0; heating = 1'b1; switched++;
         end
         tick();
      end
      chk("cl_switched", 32'(switched > 2), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
